// File: rtl/issue_scheduler.sv
// Single-issue arbiter across the int/ls/mul/div queues. It reserves each grant's fixed-latency
// CDB writeback slot up front, so results never collide on the CDB.
module issue_scheduler #(
    parameter int unsigned INT_LAT = 1,
    parameter int unsigned LS_LAT  = 2,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       ready_int,
    input  logic       ready_ls,
    input  logic       ready_mul,
    input  logic       ready_div,
    output logic       issue_int,
    output logic       issue_ls,
    output logic       issue_mul,
    output logic       issue_div,
    output logic       cdb_valid,
    output logic [1:0] cdb_unit
);

    localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    logic [DIV_LAT:0]      r_res;
    logic [DIV_LAT:0][1:0] r_own;
    logic [CNT_W-1:0]      r_div_cnt;
    logic                  r_rr;

    logic [DIV_LAT:0]      w_res_nxt;
    logic [DIV_LAT:0][1:0] w_own_nxt;
    logic [CNT_W-1:0]      w_div_cnt_nxt;
    logic                  w_rr_nxt;

    logic w_elig_int, w_elig_ls, w_elig_mul, w_elig_div;
    logic w_gnt_int, w_gnt_ls, w_gnt_mul, w_gnt_div;
    logic w_int_ls_free;

    // rst_n gates eligibility so no grant leaks out while reset is held
    always_comb begin
        w_elig_int = ready_int & ~r_res[INT_LAT] & ~flush & rst_n;
        w_elig_ls  = ready_ls  & ~r_res[LS_LAT]  & ~flush & rst_n;
        w_elig_mul = ready_mul & ~r_res[MUL_LAT] & ~flush & rst_n;
        w_elig_div = ready_div & ~r_res[DIV_LAT] & ~flush & rst_n & (r_div_cnt == '0);

        w_int_ls_free = ~w_elig_div & ~w_elig_mul;
        w_gnt_div     = w_elig_div;
        w_gnt_mul     = w_elig_mul & ~w_elig_div;
        w_gnt_int     = w_int_ls_free & w_elig_int & (~w_elig_ls | ~r_rr);
        w_gnt_ls      = w_int_ls_free & w_elig_ls  & (~w_elig_int | r_rr);
    end

    assign issue_int = w_gnt_int;
    assign issue_ls  = w_gnt_ls;
    assign issue_mul = w_gnt_mul;
    assign issue_div = w_gnt_div;

    always_comb begin
        w_res_nxt     = {1'b0, r_res[DIV_LAT:1]};
        w_own_nxt     = {2'b00, r_own[DIV_LAT:1]};
        w_div_cnt_nxt = r_div_cnt;
        w_rr_nxt      = r_rr;

        // The shifted-in slot at L-1 is known free, since eligibility checked res[L]
        if (w_gnt_int) begin
            w_res_nxt[INT_LAT-1] = 1'b1;
            w_own_nxt[INT_LAT-1] = 2'd0;
            w_rr_nxt             = 1'b1;
        end
        if (w_gnt_ls) begin
            w_res_nxt[LS_LAT-1] = 1'b1;
            w_own_nxt[LS_LAT-1] = 2'd1;
            w_rr_nxt            = 1'b0;
        end
        if (w_gnt_mul) begin
            w_res_nxt[MUL_LAT-1] = 1'b1;
            w_own_nxt[MUL_LAT-1] = 2'd2;
        end

        if (w_gnt_div) begin
            w_res_nxt[DIV_LAT-1] = 1'b1;
            w_own_nxt[DIV_LAT-1] = 2'd3;
            w_div_cnt_nxt        = CNT_W'(DIV_LAT - 1);
        end else if (r_div_cnt != '0) begin
            w_div_cnt_nxt = r_div_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res     <= '0;
            r_own     <= '0;
            r_div_cnt <= '0;
            r_rr      <= 1'b0;
        end else begin
            r_res     <= w_res_nxt;
            r_own     <= w_own_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_rr      <= w_rr_nxt;
        end
    end

    assign cdb_valid = r_res[0];
    assign cdb_unit  = r_own[0];

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: an absolute-time CDB slot model checked every cycle, plus directed
// vectors with literal expectations.
module tb_issue_scheduler;

    localparam int unsigned INT_LAT = 1;
    localparam int unsigned LS_LAT  = 2;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 6;
    localparam int unsigned N       = 64;

    localparam logic [3:0] R_INT = 4'b0001;
    localparam logic [3:0] R_LS  = 4'b0010;
    localparam logic [3:0] R_MUL = 4'b0100;
    localparam logic [3:0] R_DIV = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       ready_int = 1'b0, ready_ls = 1'b0, ready_mul = 1'b0, ready_div = 1'b0;
    logic       issue_int, issue_ls, issue_mul, issue_div;
    logic       cdb_valid;
    logic [1:0] cdb_unit;

    int total = 0;
    int bad   = 0;

    issue_scheduler #(
        .INT_LAT(INT_LAT),
        .LS_LAT (LS_LAT),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .ready_int(ready_int),
        .ready_ls (ready_ls),
        .ready_mul(ready_mul),
        .ready_div(ready_div),
        .issue_int(issue_int),
        .issue_ls (issue_ls),
        .issue_mul(issue_mul),
        .issue_div(issue_div),
        .cdb_valid(cdb_valid),
        .cdb_unit (cdb_unit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
        end
    endtask

    function automatic logic [7:0] issue_vec();
        return {4'b0, issue_div, issue_mul, issue_ls, issue_int};
    endfunction

    function automatic logic [7:0] cdb_vec();
        return {5'b0, cdb_valid, cdb_unit};
    endfunction

    // Model: slots indexed by absolute cycle number, divider busy until an absolute cycle
    bit          m_valid [N];
    logic [1:0]  m_own   [N];
    int unsigned cyc      = 0;
    int unsigned div_next = 0;
    bit          m_rr     = 1'b0;

    always @(negedge clk) begin
        logic [3:0]  g;
        logic [2:0]  exp_cdb;
        bit          e_int, e_ls, e_mul, e_div;
        int unsigned lat;
        logic [1:0]  id;
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                m_valid[i] = 1'b0;
                m_own[i]   = 2'd0;
            end
            div_next = cyc;
            m_rr     = 1'b0;
            chk("model_issue_rst", issue_vec(), 8'h00);
            chk("model_cdb_rst", cdb_vec(), 8'h00);
        end else begin
            exp_cdb = m_valid[cyc % N] ? {1'b1, m_own[cyc % N]} : 3'b000;
            e_int = ready_int && !flush && !m_valid[(cyc + INT_LAT) % N];
            e_ls  = ready_ls  && !flush && !m_valid[(cyc + LS_LAT) % N];
            e_mul = ready_mul && !flush && !m_valid[(cyc + MUL_LAT) % N];
            e_div = ready_div && !flush && !m_valid[(cyc + DIV_LAT) % N] && (cyc >= div_next);
            if (e_div)               g = R_DIV;
            else if (e_mul)          g = R_MUL;
            else if (e_int && e_ls)  g = m_rr ? R_LS : R_INT;
            else if (e_int)          g = R_INT;
            else if (e_ls)           g = R_LS;
            else                     g = 4'b0000;
            chk("model_issue", issue_vec(), {4'b0, g});
            chk("model_cdb", cdb_vec(), {5'b0, exp_cdb});

            m_valid[cyc % N] = 1'b0;
            m_own[cyc % N]   = 2'd0;
            lat = 0;
            id  = 2'd0;
            case (g)
                R_INT: begin lat = INT_LAT; id = 2'd0; m_rr = 1'b1; end
                R_LS:  begin lat = LS_LAT;  id = 2'd1; m_rr = 1'b0; end
                R_MUL: begin lat = MUL_LAT; id = 2'd2; end
                R_DIV: begin lat = DIV_LAT; id = 2'd3; div_next = cyc + DIV_LAT; end
                default: ;
            endcase
            if (lat != 0) begin
                m_valid[(cyc + lat) % N] = 1'b1;
                m_own[(cyc + lat) % N]   = id;
            end
        end
        cyc++;
    end

    task automatic drive(input logic [3:0] rdy, input logic fl);
        {ready_div, ready_mul, ready_ls, ready_int} = rdy;
        flush = fl;
    endtask

    task automatic go(input logic [3:0] rdy, input logic fl);
        @(posedge clk);
        #1;
        drive(rdy, fl);
        @(negedge clk);
    endtask

    initial begin
        // Reset with every ready high: no grant may escape
        drive(4'b1111, 1'b0);
        @(negedge clk);
        chk("reset_issue", issue_vec(), 8'h00);
        chk("reset_cdb", cdb_vec(), 8'h00);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 1'b0);
        @(negedge clk);

        // Single int op: CDB one cycle later, for one cycle only
        go(R_INT, 1'b0);
        chk("t1_issue_int", issue_vec(), 8'h01);
        go(4'b0000, 1'b0);
        chk("t1_cdb_t+1", cdb_vec(), 8'h04);
        go(4'b0000, 1'b0);
        chk("t1_cdb_t+2", cdb_vec(), 8'h00);

        // mul beats ls; ls blocked by the mul slot at t+2
        go(R_MUL | R_LS, 1'b0);
        chk("t2_mul_t", issue_vec(), 8'h04);
        go(R_LS, 1'b0);
        chk("t2_ls_t+1", issue_vec(), 8'h02);
        go(R_LS, 1'b0);
        chk("t2_ls_blocked_t+2", issue_vec(), 8'h00);
        go(R_LS, 1'b0);
        chk("t2_ls_t+3", issue_vec(), 8'h02);
        chk("t2_cdb_t+3_ls", cdb_vec(), 8'h05);
        go(4'b0000, 1'b0);
        chk("t2_cdb_t+4_mul", cdb_vec(), 8'h06);
        go(4'b0000, 1'b0);
        chk("t2_cdb_t+5_ls", cdb_vec(), 8'h05);
        repeat (8) go(4'b0000, 1'b0);

        // Divider held ready: non-pipelined, one grant every DIV_LAT cycles
        for (int i = 0; i < 20; i++) begin
            go(R_DIV, 1'b0);
            chk("t3_div_issue", issue_vec(), (i % 6 == 0) ? 8'h08 : 8'h00);
            chk("t3_div_cdb", cdb_vec(), (i > 0 && i % 6 == 0) ? 8'h07 : 8'h00);
        end
        repeat (8) go(4'b0000, 1'b0);

        // int and ls both held; rr is 0 since the last int/ls grant went to ls
        go(R_INT | R_LS, 1'b0);
        chk("t4_c0_int", issue_vec(), 8'h01);
        go(R_INT | R_LS, 1'b0);
        chk("t4_c1_ls", issue_vec(), 8'h02);
        go(R_INT | R_LS, 1'b0);
        chk("t4_c2_ls_int_slot_taken", issue_vec(), 8'h02);
        repeat (5) go(R_INT | R_LS, 1'b0);
        repeat (4) go(4'b0000, 1'b0);

        // flush blocks grants but the earlier int still gets its slot
        go(R_INT, 1'b0);
        chk("t5_int_before_flush", issue_vec(), 8'h01);
        go(4'b1111, 1'b1);
        chk("t5_flush_no_issue", issue_vec(), 8'h00);
        chk("t5_flush_cdb", cdb_vec(), 8'h04);
        repeat (8) go(4'b0000, 1'b0);

        // Reset while the divider is busy drops its slot and its occupancy
        go(R_DIV, 1'b0);
        chk("t6_div_t", issue_vec(), 8'h08);
        repeat (3) go(4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_cdb", cdb_vec(), 8'h00);
        @(posedge clk);
        #1;
        drive(R_DIV, 1'b0);
        @(negedge clk);
        chk("t6_rst_issue", issue_vec(), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_div_after_rst", issue_vec(), 8'h08);
        go(4'b0000, 1'b0);
        chk("t6_old_slot_dropped", cdb_vec(), 8'h00);
        repeat (4) go(4'b0000, 1'b0);
        go(4'b0000, 1'b0);
        chk("t6_new_div_cdb", cdb_vec(), 8'h07);
        repeat (3) go(4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
